// File: rtl/instr_fetch_pkg.sv
// Shared constants for the fetch stage and the decoder: PC select encodings,
// FSM state encoding and default reset/trap vectors.
package instr_fetch_pkg;

    localparam logic [1:0] PCSEL_REG    = 2'b00;
    localparam logic [1:0] PCSEL_BRANCH = 2'b01;
    localparam logic [1:0] PCSEL_JUMP   = 2'b10;
    localparam logic [1:0] PCSEL_SEQ    = 2'b11;

    localparam logic [0:0] StFetch = 1'b0;
    localparam logic [0:0] StIssue = 1'b1;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
    localparam logic [31:0] TRAP_PC          = 32'h0000_0080;

endpackage

// File: rtl/next_pc_calc.sv
// Combinational next-PC selection for the fetch stage (register, branch, jump, sequential).
module next_pc_calc
    import instr_fetch_pkg::*;
(
    input  logic [31:0] pc_plus4,
    input  logic [31:0] instruction,
    input  logic [1:0]  pc_sel,
    input  logic        bce_taken,
    input  logic [31:0] rs_value,
    output logic [31:0] next_pc
);

    logic [31:0] branch_off;
    logic [7:0]  unused_bits;

    assign branch_off  = {{14{instruction[15]}}, instruction[15:0], 2'b00};
    assign unused_bits = {instruction[31:26], rs_value[1:0]};

    always_comb begin
        next_pc = pc_plus4;
        unique case (pc_sel)
            PCSEL_REG:    next_pc = {rs_value[31:2], 2'b00};
            PCSEL_BRANCH: next_pc = bce_taken ? (pc_plus4 + branch_off) : pc_plus4;
            PCSEL_JUMP:   next_pc = {pc_plus4[31:28], instruction[25:0], 2'b00};
            PCSEL_SEQ:    next_pc = pc_plus4;
            default:      next_pc = pc_plus4;
        endcase
    end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch stage: PC register, imem req/ack fetch, valid/ready issue to decoder.
// Optional illegal-instruction trap enabled by defining IFETCH_ILLEGAL_TRAP_EN.
module instr_fetch
    import instr_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_data,
    output logic [31:0] instruction,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    input  logic [1:0]  pc_sel,
    input  logic        bce_taken,
    input  logic [31:0] rs_value,
    input  logic        is_illegal,
    output logic [31:0] epc
);

    logic [0:0]  state_q, state_d;
    logic        started_q;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] calc_pc;
    logic [31:0] target_pc;
    logic        accept;

    // started_q keeps imem_req low through reset and for the cycle it is released,
    // so a stale ack for an aborted request cannot be captured.
    assign imem_req    = (state_q == StFetch) && started_q;
    assign imem_addr   = pc_q;
    assign instr_valid = (state_q == StIssue);
    assign instruction = instr_q;
    assign pc          = pc_q;
    assign pc_plus4    = pc_q + 32'd4;
    assign accept      = instr_valid && instr_ready;

    next_pc_calc u_next_pc_calc (
        .pc_plus4    (pc_plus4),
        .instruction (instr_q),
        .pc_sel      (pc_sel),
        .bce_taken   (bce_taken),
        .rs_value    (rs_value),
        .next_pc     (calc_pc)
    );

`ifdef IFETCH_ILLEGAL_TRAP_EN
    logic [31:0] epc_q;

    assign target_pc = is_illegal ? TRAP_PC : calc_pc;
    assign epc       = epc_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            epc_q <= 32'h0;
        end else if (accept && is_illegal) begin
            epc_q <= pc_q;
        end
    end
`else
    logic unused_illegal;

    assign unused_illegal = is_illegal;
    assign target_pc      = calc_pc;
    assign epc            = 32'h0;
`endif

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        unique case (state_q)
            StFetch: begin
                if (imem_req && imem_ack) begin
                    instr_d = imem_data;
                    state_d = StIssue;
                end
            end
            StIssue: begin
                if (instr_ready) begin
                    pc_d    = target_pc;
                    state_d = StFetch;
                end
            end
            default: state_d = StFetch;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StFetch;
            started_q <= 1'b0;
            pc_q      <= RESET_PC;
            instr_q   <= 32'h0;
        end else begin
            state_q   <= state_d;
            started_q <= 1'b1;
            pc_q      <= pc_d;
            instr_q   <= instr_d;
        end
    end

endmodule

// File: tb/tb_instr_fetch.sv
// Directed self-checking bench for instr_fetch with an expected-fetch-address scoreboard.
module tb_instr_fetch;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_data;
    logic [31:0] instruction;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic [1:0]  pc_sel;
    logic        bce_taken;
    logic [31:0] rs_value;
    logic        is_illegal;
    logic [31:0] epc;

    int          checks = 0;
    int          failures = 0;
    logic [31:0] exp_q[$];
    logic [31:0] cur_pc;
    logic [31:0] cur_instr;

    always #5 clk = ~clk;

    instr_fetch dut (
        .clk         (clk),
        .rst         (rst),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_data   (imem_data),
        .instruction (instruction),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .pc          (pc),
        .pc_plus4    (pc_plus4),
        .pc_sel      (pc_sel),
        .bce_taken   (bce_taken),
        .rs_value    (rs_value),
        .is_illegal  (is_illegal),
        .epc         (epc)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, expv);
        end
    endtask

    // Called at a negedge: waits (bounded) for a request, checks its address against
    // the scoreboard, answers with zero wait and checks the issued instruction.
    task automatic fetch(input logic [31:0] data, input bit immediate);
        int n = 0;
        logic [31:0] expa;
        if (immediate) chk("req_immediate", {31'h0, imem_req}, 32'h1);
        while (imem_req !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (imem_req !== 1'b1) chk("req_timeout", {31'h0, imem_req}, 32'h1);
        expa = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hxxxx_xxxx;
        chk("imem_addr", imem_addr, expa);
        cur_pc    = expa;
        cur_instr = data;
        imem_ack  = 1'b1;
        imem_data = data;
        @(negedge clk);
        imem_ack  = 1'b0;
        imem_data = 32'h0;
        chk("instr_valid", {31'h0, instr_valid}, 32'h1);
        chk("instruction", instruction, data);
        chk("pc", pc, cur_pc);
        chk("pc_plus4", pc_plus4, cur_pc + 32'd4);
    endtask

    task automatic accept(input logic [1:0] sel, input logic bce, input logic [31:0] rs,
                          input logic ill, input int hold, input logic [31:0] next);
        instr_ready = 1'b0;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk("hold_valid", {31'h0, instr_valid}, 32'h1);
            chk("hold_req", {31'h0, imem_req}, 32'h0);
            chk("hold_instr", instruction, cur_instr);
            chk("hold_pc", pc, cur_pc);
        end
        pc_sel      = sel;
        bce_taken   = bce;
        rs_value    = rs;
        is_illegal  = ill;
        instr_ready = 1'b1;
        exp_q.push_back(next);
        @(negedge clk);
        instr_ready = 1'b0;
        pc_sel      = 2'b00;
        bce_taken   = 1'b0;
        rs_value    = 32'hDEAD_0000;
        is_illegal  = 1'b0;
        chk("valid_drop", {31'h0, instr_valid}, 32'h0);
    endtask

    initial begin
        logic [31:0] trap_next;
        logic [31:0] trap_epc;
        rst         = 1'b1;
        imem_ack    = 1'b0;
        imem_data   = 32'h0;
        instr_ready = 1'b0;
        pc_sel      = 2'b11;
        bce_taken   = 1'b0;
        rs_value    = 32'h0;
        is_illegal  = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_req", {31'h0, imem_req}, 32'h0);
        chk("rst_valid", {31'h0, instr_valid}, 32'h0);
        chk("rst_instr", instruction, 32'h0);
        chk("rst_pc", pc, 32'h0);
        chk("rst_epc", epc, 32'h0);
        rst = 1'b0;
        #1 chk("rel_req", {31'h0, imem_req}, 32'h0);
        @(negedge clk);

        // Zero-wait sequential fetches from RESET_PC.
        exp_q.push_back(32'h0);
        fetch(32'h0000_0000, 1'b1);
        accept(2'b11, 1'b0, 32'h0, 1'b0, 0, 32'h4);
        fetch(32'h0000_0001, 1'b1);
        accept(2'b11, 1'b0, 32'h0, 1'b0, 0, 32'h8);
        // j with index 0x40 -> 0x100
        fetch(32'h0800_0040, 1'b1);
        accept(2'b10, 1'b0, 32'h0, 1'b0, 0, 32'h100);
        // branch imm FFFE taken at 0x100 -> 0x0FC
        fetch(32'h1000_FFFE, 1'b1);
        accept(2'b01, 1'b1, 32'h0, 1'b0, 0, 32'h0FC);
        fetch(32'h0000_0002, 1'b1);
        accept(2'b00, 1'b0, 32'h100, 1'b0, 0, 32'h100);
        // same branch not taken -> 0x104
        fetch(32'h1000_FFFE, 1'b1);
        accept(2'b01, 1'b0, 32'h0, 1'b0, 0, 32'h104);
        fetch(32'h0000_0003, 1'b1);
        accept(2'b00, 1'b1, 32'h1000_0040, 1'b0, 0, 32'h1000_0040);
        // j index 0x10 keeps upper nibble of pc_plus4 -> 0x1000_0040
        fetch(32'h0800_0010, 1'b1);
        accept(2'b10, 1'b0, 32'h0, 1'b0, 0, 32'h1000_0040);
        // jr with misaligned rs -> low bits discarded
        fetch(32'h0000_0004, 1'b1);
        accept(2'b00, 1'b0, 32'h203, 1'b0, 0, 32'h200);
        // decoder stalls 3 cycles
        fetch(32'h1234_5678, 1'b1);
        accept(2'b11, 1'b0, 32'h0, 1'b0, 3, 32'h204);
        fetch(32'h0000_0005, 1'b1);
        accept(2'b00, 1'b0, 32'h40, 1'b0, 0, 32'h40);

        // Illegal instruction with a taken branch at 0x40 (imm 4 -> 0x54).
`ifdef IFETCH_ILLEGAL_TRAP_EN
        trap_next = 32'h80;
        trap_epc  = 32'h40;
`else
        trap_next = 32'h54;
        trap_epc  = 32'h0;
`endif
        fetch(32'h1000_0004, 1'b1);
        accept(2'b01, 1'b1, 32'h0, 1'b1, 0, trap_next);
        chk("epc", epc, trap_epc);
        fetch(32'h0000_0006, 1'b1);
        accept(2'b00, 1'b0, 32'hFFFF_FFFC, 1'b0, 0, 32'hFFFF_FFFC);
        fetch(32'h0000_0007, 1'b1);
        accept(2'b11, 1'b0, 32'h0, 1'b0, 0, 32'h0);

        // Reset during an outstanding request; acks during and after reset are ignored.
        chk("pre_rst_req", {31'h0, imem_req}, 32'h1);
        chk("pre_rst_addr", imem_addr, exp_q.pop_front());
        rst = 1'b1;
        #1 chk("rst_req_drop", {31'h0, imem_req}, 32'h0);
        @(negedge clk);
        imem_ack  = 1'b1;
        imem_data = 32'hDEAD_BEEF;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        imem_ack  = 1'b0;
        imem_data = 32'h0;
        chk("abort_instr", instruction, 32'h0);
        chk("abort_valid", {31'h0, instr_valid}, 32'h0);
        exp_q.push_back(32'h0);
        fetch(32'h0000_0008, 1'b1);
        accept(2'b11, 1'b0, 32'h0, 1'b0, 0, 32'h4);
        fetch(32'h0000_0009, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction fetch stage sitting directly upstream of the instruction decoder. Holds the program counter, fetches one 32-bit word per instruction from instruction memory over a req/ack handshake, and presents it to the decoder with a valid/ready handshake. On acceptance it uses the decoder's 2-bit PC select, the branch-condition result and the rs register value to compute and register the next PC. No delay slots: the link value for jal/jalr is `pc_plus4` of the jumping instruction.

## Interface
- `RESET_PC`, 32'h0000_0000, PC loaded on reset
- `TRAP_PC`, 32'h0000_0080, PC loaded when an illegal instruction is accepted (trap build only)
- `clk`  in  1  single clock, all state on rising edge
- `rst`  in  1  asynchronous, active-high reset
- `imem_req`  out  1  fetch request, held until `imem_ack`
- `imem_addr`  out  32  word address of fetch (= `pc`, bits [1:0] always 0)
- `imem_ack`  in  1  data valid on `imem_data` this cycle
- `imem_data`  in  32  fetched instruction word
- `instruction`  out  32  registered instruction presented to decoder
- `instr_valid`  out  1  `instruction` is valid
- `instr_ready`  in  1  downstream accepts instruction this cycle
- `pc`  out  32  address of presented instruction
- `pc_plus4`  out  32  `pc + 4`, mod 2^32
- `pc_sel`  in  2  decoder PC select: 00 register (jr/jalr), 01 branch, 10 jump (j/jal), 11 sequential
- `bce_taken`  in  1  branch condition true; meaningful only when `pc_sel`=01
- `rs_value`  in  32  GPR[rs], jump target when `pc_sel`=00
- `is_illegal`  in  1  decoder flags `instruction` as undefined
- `epc`  out  32  PC of last trapped instruction (trap build only; tied 0 otherwise)

## Operation
- FSM states: FETCH, ISSUE. Reset state FETCH.
- FETCH: `imem_req`=1, `imem_addr`=`pc`. On `imem_ack`: capture `imem_data` into `instruction`, go ISSUE. `imem_ack` while `imem_req`=0 is ignored.
- ISSUE: `instr_valid`=1, `imem_req`=0. While `instr_ready`=0, hold `instruction`, `pc` and state. On `instr_ready`=1: register next PC, go FETCH.
- Next PC (evaluated in the accept cycle from current inputs):
  - 11: `pc_plus4`
  - 01: `bce_taken` ? `pc_plus4 + (sext(instruction[15:0]) << 2)` : `pc_plus4`
  - 10: `{pc_plus4[31:28], instruction[25:0], 2'b00}`
  - 00: `{rs_value[31:2], 2'b00}` (low bits discarded)
- All additions wrap mod 2^32; `pc`=32'hFFFF_FFFC sequential gives 0.
- Reset values: `pc`=`RESET_PC`, `instruction`=0, `instr_valid`=0, `imem_req`=0, `epc`=0, state FETCH; `imem_req` asserts first cycle after `rst` deasserts.
- `rst` mid-fetch drops `imem_req` immediately; an ack arriving during or after reset for the aborted request is not captured unless a new request is outstanding.

## Timing
- Minimum 2 cycles per instruction: ack in cycle N (FETCH) -> `instr_valid` cycle N+1 -> accept in N+1 -> `imem_req` for new PC cycle N+2.
- `imem_ack` in the same cycle `imem_req` first rises is legal (zero-wait memory).
- Outputs `instruction`, `pc`, `instr_valid`, `imem_req`, `imem_addr` are registered/state-decoded; no combinational path from `instr_ready` to them.
- `pc_sel`, `bce_taken`, `rs_value`, `is_illegal` sampled only at the accepting edge.

## Configuration
- `IFETCH_ILLEGAL_TRAP_EN` defined: accept with `is_illegal`=1 overrides `pc_sel`; next PC = `TRAP_PC`, `epc` <= `pc`. Trap takes priority over any branch/jump.
- Undefined: `is_illegal` ignored, next PC from `pc_sel` as normal, `epc` tied to 0.

## Structure
- Shared package: PC select encodings (`PCSEL_REG`=00, `PCSEL_BRANCH`=01, `PCSEL_JUMP`=10, `PCSEL_SEQ`=11), FSM state encoding, default `RESET_PC`/`TRAP_PC`. Decoder uses the same PC select constants.
- One sub-module: `next_pc_calc`, purely combinational (pc_plus4, instruction, pc_sel, bce_taken, rs_value -> next_pc).

## Test plan
- Reset, memory acks every request with 0 wait: `imem_addr` sequence 0x0, 0x4, 0x8; `instr_valid` high every second cycle.
- `pc`=0x100, `pc_sel`=01, `bce_taken`=1, imm=16'hFFFE -> next fetch 0x0FC; same with `bce_taken`=0 -> 0x104.
- `pc`=0x1000_0040, `pc_sel`=10, iindex=26'h0000010 -> 0x1000_0040; `pc_sel`=00, `rs_value`=0x203 -> 0x200.
- `instr_ready` held low 3 cycles in ISSUE: `instruction`/`pc` stable, no `imem_req`; accept on 4th cycle -> next fetch one cycle later.
- `rst` pulsed while `imem_req`=1 with ack 1 cycle later: ack ignored, refetch from `RESET_PC` after release; also `pc`=0xFFFF_FFFC sequential -> 0x0.
- Trap build: `is_illegal`=1, `pc`=0x40, `pc_sel`=01 taken -> next fetch `TRAP_PC` 0x80, `epc`=0x40; non-trap build -> branch target.
